// File: rtl/ahb_lite_master_pkg.sv
// ahb_pkg: shared AHB-Lite types and constants for the AHB-Lite master.
//   htrans_t    - the two transfer types this initiator ever issues.
//   HSIZE_WORD  - fixed transfer size (32-bit word).
//   mst_state_t - pipeline occupancy, encoded directly as {a_v, d_v}, so
//                 the state bits themselves are the two phase-valid flags.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ADDR      = 2'b10,
        ADDR_DATA = 2'b11,
        DATA      = 2'b01
    } mst_state_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if: AHB-Lite bus between one initiator and one slave.
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA : initiator -> slave
//   HREADY (slave HREADYOUT), HRDATA           : slave -> initiator
//   HWPARITY                                   : initiator -> slave, only
//                                                with AHB_MST_WPARITY_EN
// Modports: master (initiator side), slave (target side).
interface ahb_lite_master_if
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    htrans_t           HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
`ifdef AHB_MST_WPARITY_EN
    logic              HWPARITY;
`endif

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
`ifdef AHB_MST_WPARITY_EN
        output HWPARITY,
`endif
        input  HREADY, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
`ifdef AHB_MST_WPARITY_EN
        input  HWPARITY,
`endif
        output HREADY, HRDATA
    );
endinterface

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: command-driven AHB-Lite initiator, single-beat NONSEQ
// read/write transfers, pipelined address/data phases, wait-state aware.
// Ports:
//   HCLK, HRESETn       - clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready - command handshake; cmd_write/cmd_addr/cmd_wdata
//   rsp_valid           - one-cycle pulse per completed transfer, with
//                         rsp_write and rsp_rdata (0 for writes)
//   dbg_state           - pipeline occupancy {a_v, d_v} as mst_state_t
//   bus                 - AHB-Lite master modport
// Optional: define AHB_MST_WPARITY_EN to add HWPARITY (odd parity of
// HWDATA for writes, 0 for reads) in the data phase.
//
// Handshake: a command transfers on a rising edge where cmd_valid &&
// cmd_ready; cmd_ready depends combinationally on HREADY, and cmd_valid
// must not depend on cmd_ready.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output mst_state_t        dbg_state,
    ahb_lite_master_if.master bus
);

    mst_state_t        state, state_nxt;
    logic              a_v, d_v;
    logic              accept;
    logic              a_nxt, d_nxt;
    logic [DATA_W-1:0] pend_wdata;
    logic              d_write;

    assign a_v       = state[1];
    assign d_v       = state[0];
    assign dbg_state = state;

    // The address slot is free when empty or when its occupant advances now.
    assign cmd_ready = !a_v || bus.HREADY;
    assign accept    = cmd_valid && cmd_ready;

    assign bus.HTRANS = a_v ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HSEL   = a_v;
    assign bus.HSIZE  = HSIZE_WORD;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        a_nxt     = accept || (a_v && !bus.HREADY);
        d_nxt     = (a_v && bus.HREADY) || (d_v && !bus.HREADY);
        state_nxt = mst_state_t'({a_nxt, d_nxt});
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bus.HADDR  <= '0;
            bus.HWRITE <= 1'b0;
            pend_wdata <= '0;
            bus.HWDATA <= '0;
            d_write    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            // HADDR/HWRITE keep their last values once the bus goes IDLE.
            if (accept) begin
                bus.HADDR  <= cmd_addr;
                bus.HWRITE <= cmd_write;
                pend_wdata <= cmd_wdata;
            end
            // Address phase advances; pend_wdata still belongs to it here
            // because a same-edge accept only overwrites it after this edge.
            if (a_v && bus.HREADY) begin
                d_write <= bus.HWRITE;
                if (bus.HWRITE) bus.HWDATA <= pend_wdata;
            end
            rsp_valid <= d_v && bus.HREADY;
            if (d_v && bus.HREADY) begin
                rsp_write <= d_write;
                rsp_rdata <= d_write ? '0 : bus.HRDATA;
            end
        end
    end

`ifdef AHB_MST_WPARITY_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            bus.HWPARITY <= 1'b0;
        else if (a_v && bus.HREADY)
            bus.HWPARITY <= bus.HWRITE ? ~(^pend_wdata) : 1'b0;
    end
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;
    import ahb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    mst_state_t  dbg_state;

    int vectors;
    int miscompares;

    ahb_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .dbg_state (dbg_state),
        .bus       (bus.master)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_write"}, 64'(rsp_write), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_hsel"},      64'(bus.HSEL),  64'd0);
        chk({tag, "_haddr"},     64'(bus.HADDR), 64'd0);
        chk({tag, "_htrans"},    64'(bus.HTRANS), 64'd0);
        chk({tag, "_hwrite"},    64'(bus.HWRITE), 64'd0);
        chk({tag, "_hwdata"},    64'(bus.HWDATA), 64'd0);
        chk({tag, "_state"},     64'(dbg_state), 64'd0);
`ifdef AHB_MST_WPARITY_EN
        chk({tag, "_hwparity"},  64'(bus.HWPARITY), 64'd0);
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        bus.HREADY  = 1'b1;
        bus.HRDATA  = '0;

        #1;
        check_reset_values("rst");
        chk("rst_hsize", 64'(bus.HSIZE), 64'h2);
        step();
        step();
        rst_n = 1'b1;

        // ---- single write, zero wait states
        step();
        drive_cmd(1'b1, 32'h0000_0004, 32'h0000_FFFF);
        #1 chk("w1_cmd_ready", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
        chk("w1_htrans", 64'(bus.HTRANS), 64'h2);
        chk("w1_hsel",   64'(bus.HSEL),   64'd1);
        chk("w1_haddr",  64'(bus.HADDR),  64'h4);
        chk("w1_hwrite", 64'(bus.HWRITE), 64'd1);
        chk("w1_state",  64'(dbg_state),  64'(ADDR));
        step();
        chk("w1_htrans_idle", 64'(bus.HTRANS), 64'h0);
        chk("w1_hsel_idle",   64'(bus.HSEL),   64'd0);
        chk("w1_haddr_hold",  64'(bus.HADDR),  64'h4);
        chk("w1_hwdata",      64'(bus.HWDATA), 64'h0000_FFFF);
        chk("w1_rsp_early",   64'(rsp_valid),  64'd0);
        chk("w1_state_data",  64'(dbg_state),  64'(DATA));
        step();
        chk("w1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("w1_rsp_write", 64'(rsp_write), 64'd1);
        chk("w1_rsp_rdata", 64'(rsp_rdata), 64'd0);
        step();
        chk("w1_rsp_pulse", 64'(rsp_valid), 64'd0);

        // ---- single read
        drive_cmd(1'b0, 32'h0000_0000, 32'h1234_0000);
        step();
        cmd_valid = 1'b0;
        chk("r1_htrans", 64'(bus.HTRANS), 64'h2);
        chk("r1_haddr",  64'(bus.HADDR),  64'h0);
        chk("r1_hwrite", 64'(bus.HWRITE), 64'd0);
        step();
        bus.HRDATA = 32'h0000_A5A5;
        chk("r1_hwdata_hold", 64'(bus.HWDATA), 64'h0000_FFFF);
        chk("r1_htrans_idle", 64'(bus.HTRANS), 64'h0);
        step();
        chk("r1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("r1_rsp_write", 64'(rsp_write), 64'd0);
        chk("r1_rsp_rdata", 64'(rsp_rdata), 64'h0000_A5A5);
        step();

        // ---- back-to-back write then read
        drive_cmd(1'b1, 32'h0000_0008, 32'h1234_5678);
        step();
        drive_cmd(1'b0, 32'h0000_000C, 32'h0);
        #1;
        chk("b2b_w_htrans", 64'(bus.HTRANS), 64'h2);
        chk("b2b_w_haddr",  64'(bus.HADDR),  64'h8);
        chk("b2b_w_hwrite", 64'(bus.HWRITE), 64'd1);
        chk("b2b_ready_1",  64'(cmd_ready),  64'd1);
        step();
        cmd_valid  = 1'b0;
        bus.HRDATA = 32'h0000_BEEF;
        chk("b2b_r_htrans", 64'(bus.HTRANS), 64'h2);
        chk("b2b_r_haddr",  64'(bus.HADDR),  64'hC);
        chk("b2b_r_hwrite", 64'(bus.HWRITE), 64'd0);
        chk("b2b_w_hwdata", 64'(bus.HWDATA), 64'h1234_5678);
        chk("b2b_state",    64'(dbg_state),  64'(ADDR_DATA));
        chk("b2b_ready_2",  64'(cmd_ready),  64'd1);
        step();
        chk("b2b_rsp1_valid", 64'(rsp_valid), 64'd1);
        chk("b2b_rsp1_write", 64'(rsp_write), 64'd1);
        chk("b2b_rsp1_rdata", 64'(rsp_rdata), 64'd0);
        chk("b2b_htrans_idle", 64'(bus.HTRANS), 64'h0);
        step();
        chk("b2b_rsp2_valid", 64'(rsp_valid), 64'd1);
        chk("b2b_rsp2_write", 64'(rsp_write), 64'd0);
        chk("b2b_rsp2_rdata", 64'(rsp_rdata), 64'h0000_BEEF);
        step();
        chk("b2b_rsp_done", 64'(rsp_valid), 64'd0);

        // ---- two wait states in a read data phase, write queued behind it
        drive_cmd(1'b0, 32'h0000_0010, 32'h0);
        step();
        drive_cmd(1'b1, 32'h0000_0014, 32'h0000_CAFE);
        #1 chk("ws_r_haddr", 64'(bus.HADDR), 64'h10);
        step();
        cmd_valid  = 1'b0;
        bus.HREADY = 1'b0;
        bus.HRDATA = 32'h0000_DEAD;
        #1;
        chk("ws_w_haddr",  64'(bus.HADDR),  64'h14);
        chk("ws_ready_0",  64'(cmd_ready),  64'd0);
        chk("ws_state",    64'(dbg_state),  64'(ADDR_DATA));
        step();
        chk("ws1_haddr",   64'(bus.HADDR),  64'h14);
        chk("ws1_htrans",  64'(bus.HTRANS), 64'h2);
        chk("ws1_hwrite",  64'(bus.HWRITE), 64'd1);
        chk("ws1_ready",   64'(cmd_ready),  64'd0);
        chk("ws1_rsp",     64'(rsp_valid),  64'd0);
        step();
        chk("ws2_haddr",   64'(bus.HADDR),  64'h14);
        chk("ws2_htrans",  64'(bus.HTRANS), 64'h2);
        chk("ws2_rsp",     64'(rsp_valid),  64'd0);
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h0000_1111;
        step();
        chk("ws_rsp1_valid", 64'(rsp_valid), 64'd1);
        chk("ws_rsp1_write", 64'(rsp_write), 64'd0);
        chk("ws_rsp1_rdata", 64'(rsp_rdata), 64'h0000_1111);
        chk("ws_hwdata",     64'(bus.HWDATA), 64'h0000_CAFE);
        chk("ws_htrans_idle", 64'(bus.HTRANS), 64'h0);
        step();
        chk("ws_rsp2_valid", 64'(rsp_valid), 64'd1);
        chk("ws_rsp2_write", 64'(rsp_write), 64'd1);
        chk("ws_rsp2_rdata", 64'(rsp_rdata), 64'd0);
        step();

        // ---- HREADY low while idle has no effect
        bus.HREADY = 1'b0;
        step();
        chk("idle_wait_state", 64'(dbg_state), 64'(IDLE));
        chk("idle_wait_rsp",   64'(rsp_valid), 64'd0);
        chk("idle_wait_ready", 64'(cmd_ready), 64'd1);
        bus.HREADY = 1'b1;

        // ---- reset while in ADDR_DATA
        drive_cmd(1'b1, 32'h0000_0020, 32'h0000_AAAA);
        step();
        drive_cmd(1'b0, 32'h0000_0024, 32'h0);
        step();
        cmd_valid  = 1'b0;
        bus.HRDATA = 32'h0000_5555;
        chk("mr_state", 64'(dbg_state), 64'(ADDR_DATA));
        #1 rst_n = 1'b0;
        #1 check_reset_values("mr");
        step();
        chk("mr_rsp_a", 64'(rsp_valid), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mr_rsp_b", 64'(rsp_valid), 64'd0);
        chk("mr_state_idle", 64'(dbg_state), 64'(IDLE));

        drive_cmd(1'b0, 32'h0000_0028, 32'h0);
        bus.HRDATA = 32'h0000_7777;
        step();
        cmd_valid = 1'b0;
        chk("pr_haddr", 64'(bus.HADDR), 64'h28);
        chk("pr_htrans", 64'(bus.HTRANS), 64'h2);
        step();
        chk("pr_rsp_early", 64'(rsp_valid), 64'd0);
        step();
        chk("pr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("pr_rsp_write", 64'(rsp_write), 64'd0);
        chk("pr_rsp_rdata", 64'(rsp_rdata), 64'h0000_7777);
        step();

`ifdef AHB_MST_WPARITY_EN
        // ---- write parity
        drive_cmd(1'b1, 32'h0000_0030, 32'h0000_0001);
        step();
        drive_cmd(1'b1, 32'h0000_0034, 32'h0000_0003);
        step();
        drive_cmd(1'b0, 32'h0000_0038, 32'h0);
        chk("par_w1", 64'(bus.HWPARITY), 64'd0);
        step();
        cmd_valid = 1'b0;
        chk("par_w3", 64'(bus.HWPARITY), 64'd1);
        step();
        chk("par_rd", 64'(bus.HWPARITY), 64'd0);
        step();
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
